// File: rtl/fifo_word_serializer_if.sv
// FIFO read handshake plus framed serial output, grouped for the word serializer.
// master: the serializer side; slave: the FIFO / line-driver side.
interface fifo_word_serializer_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd;
  logic                  tx_bit;
  logic                  tx_valid;
  logic                  tx_sof;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd,
    output tx_bit,
    output tx_valid,
    output tx_sof
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd,
    input  tx_bit,
    input  tx_valid,
    input  tx_sof
  );
endinterface

// File: rtl/fifo_word_serializer.sv
// Pops words from a synchronous FIFO (read latency 1) and shifts each one out as a
// framed serial stream, holding every bit for CLK_DIV clocks.
module fifo_word_serializer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CLK_DIV    = 1,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  fifo_word_serializer_if.master  bus,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    word_count
);

  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);
  localparam logic [DivW-1:0] DivLoad = DivW'(CLK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StWait, StShift} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DivW-1:0]       div_q, div_d;
  logic                  tx_bit_q, tx_bit_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  tx_sof_q, tx_sof_d;
  logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
  logic                  rd;
  logic                  pop_ok;

  assign pop_ok = enable & ~bus.fifo_empty;

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    bit_cnt_d    = bit_cnt_q;
    div_d        = div_q;
    tx_valid_d   = tx_valid_q;
    tx_sof_d     = tx_sof_q;
    word_count_d = word_count_q;
    rd           = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pop_ok) begin
          rd      = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        sreg_d     = bus.fifo_data;
        bit_cnt_d  = LastBit;
        div_d      = DivLoad;
        tx_valid_d = 1'b1;
        tx_sof_d   = 1'b1;
        state_d    = StShift;
      end
      StShift: begin
        if (div_q != '0) begin
          div_d = div_q - 1'b1;
        end else if (bit_cnt_q != '0) begin
          div_d     = DivLoad;
          bit_cnt_d = bit_cnt_q - 1'b1;
          sreg_d    = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
          tx_sof_d  = 1'b0;
        end else begin
          // Final clock of the final bit: pops here give a single idle gap.
          word_count_d = word_count_q + 1'b1;
          tx_valid_d   = 1'b0;
          tx_sof_d     = 1'b0;
          if (pop_ok) begin
            rd      = 1'b1;
            state_d = StWait;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    tx_bit_d = tx_valid_d & (MSB_FIRST ? sreg_d[DATA_WIDTH-1] : sreg_d[0]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      sreg_q       <= '0;
      bit_cnt_q    <= '0;
      div_q        <= '0;
      tx_bit_q     <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_sof_q     <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      bit_cnt_q    <= bit_cnt_d;
      div_q        <= div_d;
      tx_bit_q     <= tx_bit_d;
      tx_valid_q   <= tx_valid_d;
      tx_sof_q     <= tx_sof_d;
      word_count_q <= word_count_d;
    end
  end

  // The pop request is combinational, so gate it with reset to keep it quiet in reset.
  assign bus.fifo_rd  = rd & rst;
  assign bus.tx_bit   = tx_bit_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_sof   = tx_sof_q;
  assign busy         = (state_q != StIdle);
  assign word_count   = word_count_q;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Scoreboard bench: two serializers (CLK_DIV=1 MSB-first, CLK_DIV=4 LSB-first) fed by queue FIFOs.
module tb_fifo_word_serializer;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en0, en1;
  logic        busy0, busy1;
  logic [15:0] wc0, wc1;

  fifo_word_serializer_if #(.DATA_WIDTH(DW)) io0 ();
  fifo_word_serializer_if #(.DATA_WIDTH(DW)) io1 ();

  fifo_word_serializer #(.DATA_WIDTH(DW), .CLK_DIV(1), .MSB_FIRST(1'b1), .CNT_WIDTH(16)) u_dut0 (
    .clk(clk), .rst(rst), .enable(en0), .bus(io0), .busy(busy0), .word_count(wc0)
  );
  fifo_word_serializer #(.DATA_WIDTH(DW), .CLK_DIV(4), .MSB_FIRST(1'b0), .CNT_WIDTH(16)) u_dut1 (
    .clk(clk), .rst(rst), .enable(en1), .bus(io1), .busy(busy1), .word_count(wc1)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc   = 0;

  logic [DW-1:0] q0[$], q1[$];  // FIFO contents
  logic [DW-1:0] e0[$], e1[$];  // words expected on the serial line
  int pos[2];
  int rdcnt[2];
  int vcnt[2];
  int first_v[2];
  int last_v[2];
  int div_of[2] = '{1, 4};
  bit msb_of[2] = '{1'b1, 1'b0};
  logic rd0, rd1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic score(int i, logic v, logic b, logic s, logic rd, logic emp);
    logic [DW-1:0] w;
    int idx;
    int nexp;
    if (rd) check("rd_while_empty", 32'(emp), 32'd0);
    if (!v) begin
      check("bit_when_idle", 32'(b), 32'd0);
    end else begin
      vcnt[i]++;
      if (first_v[i] < 0) first_v[i] = cyc;
      last_v[i] = cyc;
      nexp = (i == 0) ? e0.size() : e1.size();
      if (nexp == 0) begin
        check("valid_without_word", 32'(v), 32'd0);
      end else begin
        w   = (i == 0) ? e0[0] : e1[0];
        idx = pos[i] / div_of[i];
        check("tx_bit", 32'(b), 32'(msb_of[i] ? w[DW-1-idx] : w[idx]));
        check("tx_sof", 32'(s), 32'(pos[i] < div_of[i]));
        pos[i]++;
        if (pos[i] == DW * div_of[i]) begin
          pos[i] = 0;
          if (i == 0) void'(e0.pop_front());
          else        void'(e1.pop_front());
        end
      end
    end
  endtask

  // Sample on the falling edge, update the FIFO models just after the rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    score(0, io0.tx_valid, io0.tx_bit, io0.tx_sof, io0.fifo_rd, io0.fifo_empty);
    score(1, io1.tx_valid, io1.tx_bit, io1.tx_sof, io1.fifo_rd, io1.fifo_empty);
    rd0 = io0.fifo_rd;
    rd1 = io1.fifo_rd;
    rdcnt[0] += int'(rd0);
    rdcnt[1] += int'(rd1);
    @(posedge clk);
    #1;
    if (rd0 && q0.size() > 0) io0.fifo_data = q0.pop_front();
    if (rd1 && q1.size() > 0) io1.fifo_data = q1.pop_front();
    io0.fifo_empty = (q0.size() == 0);
    io1.fifo_empty = (q1.size() == 0);
  endtask

  task automatic clear(int i);
    rdcnt[i] = 0; vcnt[i] = 0; first_v[i] = -1; last_v[i] = -1;
  endtask

  task automatic push(int i, logic [DW-1:0] w);
    if (i == 0) begin q0.push_back(w); e0.push_back(w); io0.fifo_empty = 1'b0; end
    else        begin q1.push_back(w); e1.push_back(w); io1.fifo_empty = 1'b0; end
  endtask

  task automatic wait_rd(int i, int budget, output int t);
    bit seen = 1'b0;
    t = -1;
    for (int k = 0; k < budget && !seen; k++) begin
      tick();
      if ((i == 0) ? rd0 : rd1) begin seen = 1'b1; t = cyc; end
    end
    check("wait_rd_timeout", 32'(seen), 32'd1);
  endtask

  task automatic wait_left(int i, int left, int budget);
    int k = 0;
    while (((i == 0) ? e0.size() : e1.size()) > left && k < budget) begin tick(); k++; end
    check("drain_timeout", 32'((i == 0) ? e0.size() : e1.size()), 32'(left));
  endtask

  task automatic wait_pos(int i, int p, int budget);
    int k = 0;
    while (pos[i] != p && k < budget) begin tick(); k++; end
    check("wait_pos_timeout", 32'(pos[i]), 32'(p));
  endtask

  initial begin
    int t;
    int c0;
    logic [15:0] wc_base;
    rst = 1'b0; en0 = 1'b1; en1 = 1'b0;
    io0.fifo_empty = 1'b1; io0.fifo_data = '0;
    io1.fifo_empty = 1'b1; io1.fifo_data = '0;
    for (int i = 0; i < 2; i++) begin pos[i] = 0; clear(i); end

    // Reset held with a non-empty FIFO and enable high: nothing may move.
    push(0, 16'hA5C3);
    repeat (20) begin
      tick();
      check("rd_in_reset", 32'(rd0), 32'd0);
    end
    check("reset_valid", 32'(io0.tx_valid), 32'd0);
    check("reset_busy", 32'(busy0), 32'd0);
    check("reset_count", 32'(wc0), 32'd0);

    // Single word, CLK_DIV=1, MSB first.
    c0  = cyc;
    rst = 1'b1;
    wait_rd(0, 10, t);
    check("first_pop_cycle", 32'(t), 32'(c0 + 1));
    wait_left(0, 0, 100);
    check("single_first_valid", 32'(first_v[0]), 32'(t + 2));
    check("single_last_valid", 32'(last_v[0]), 32'(t + 17));
    check("single_valid_cycles", 32'(vcnt[0]), 32'd16);
    check("single_count", 32'(wc0), 32'd1);
    tick();
    check("single_idle", 32'(busy0), 32'd0);
    check("single_pops", 32'(rdcnt[0]), 32'd1);

    // Full FIFO of 1..32, back to back.
    en0 = 1'b0;
    clear(0);
    for (int w = 1; w <= 32; w++) push(0, 16'(w));
    wc_base = wc0;
    en0 = 1'b1;
    wait_left(0, 0, 2000);
    repeat (3) tick();
    check("burst_pops", 32'(rdcnt[0]), 32'd32);
    check("burst_valid_cycles", 32'(vcnt[0]), 32'd512);
    check("burst_span", 32'(last_v[0] - first_v[0] + 1), 32'd543);
    check("burst_count", 32'(16'(wc0 - wc_base)), 32'd32);
    check("burst_idle", 32'(busy0), 32'd0);

    // CLK_DIV=4, LSB first, word 0x0001.
    clear(1);
    push(1, 16'h0001);
    en1 = 1'b1;
    wait_left(1, 0, 200);
    check("div4_valid_cycles", 32'(vcnt[1]), 32'd64);
    check("div4_count", 32'(wc1), 32'd1);
    en1 = 1'b0;

    // Drop enable mid-word with more words queued.
    en0 = 1'b0;
    clear(0);
    push(0, 16'h1234); push(0, 16'h5678); push(0, 16'h9ABC);
    wc_base = wc0;
    en0 = 1'b1;
    wait_pos(0, 5, 50);
    en0 = 1'b0;
    wait_left(0, 2, 100);
    repeat (5) tick();
    check("disable_pops", 32'(rdcnt[0]), 32'd1);
    check("disable_count", 32'(16'(wc0 - wc_base)), 32'd1);
    check("disable_fifo_left", 32'(q0.size()), 32'd2);
    check("disable_idle", 32'(busy0), 32'd0);

    // Reset during bit 8: the word in flight is lost, the next one goes out whole.
    clear(0);
    en0 = 1'b1;
    wait_pos(0, 8, 50);
    rst = 1'b0;
    tick();
    check("rd_in_reset", 32'(rd0), 32'd0);
    check("midreset_valid", 32'(io0.tx_valid), 32'd0);
    check("midreset_busy", 32'(busy0), 32'd0);
    check("midreset_count", 32'(wc0), 32'd0);
    void'(e0.pop_front());
    pos[0] = 0;
    rst = 1'b1;
    wait_left(0, 0, 100);
    check("after_reset_count", 32'(wc0), 32'd1);
    check("after_reset_pops", 32'(rdcnt[0]), 32'd2);
    check("after_reset_fifo", 32'(q0.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fifo_word_serializer.md
Name: fifo_word_serializer

Overview:
Downstream consumer for the team's synchronous FIFO. It pops DATA_WIDTH-bit words through the FIFO read/empty handshake and shifts each word out as a framed serial bit stream. Each bit is held for a programmable number of clocks. It sits between the FIFO and a serial line driver or PHY.

Parameters:
DATA_WIDTH, 16, word width; must match the FIFO DATA_WIDTH
CLK_DIV, 1, clocks each bit is held on tx_bit; legal range >= 1
MSB_FIRST, 1, 1 = shift MSB first; 0 = shift LSB first
CNT_WIDTH, 16, width of word_count

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  reset, synchronous, active-low (0 = reset)
enable  input  1  1 = block may pop new words from the FIFO
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_WIDTH  FIFO data_out; registered, valid one cycle after fifo_rd
fifo_rd  output  1  FIFO read request; one-cycle pulse per word
tx_bit  output  1  serial data bit
tx_valid  output  1  high while tx_bit carries a word bit
tx_sof  output  1  high during the first bit period of each word
busy  output  1  high in any state other than IDLE
word_count  output  CNT_WIDTH  words fully transmitted since reset; wraps to 0

Behaviour:
- Reset (rst=0 at a clk edge):
  - fifo_rd=0, tx_bit=0, tx_valid=0, tx_sof=0, busy=0, word_count=0.
  - Divider and bit counters cleared; state=IDLE.
  - Reset dominates all other inputs.
- States: IDLE, WAIT, SHIFT.
- IDLE:
  - If enable=1 and fifo_empty=0: drive fifo_rd=1 for that cycle and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT (the cycle after the pop; FIFO read latency = 1):
  - Capture fifo_data into the shift register.
  - Load bit counter = DATA_WIDTH-1 and divider = CLK_DIV-1.
  - Go to SHIFT.
- SHIFT:
  - tx_valid=1.
  - tx_bit = current bit: MSB or LSB per MSB_FIRST.
  - tx_sof=1 only while the first bit is on the line.
  - Each bit is held exactly CLK_DIV cycles.
- End of SHIFT (final cycle of the final bit):
  - word_count increments, wrapping modulo 2^CNT_WIDTH.
  - If enable=1 and fifo_empty=0 in that cycle: assert fifo_rd and go to WAIT. Back-to-back words then have exactly one cycle with tx_valid=0 between them.
  - Otherwise go to IDLE.
- Latency:
  - fifo_rd in cycle T puts the first bit on tx_bit in T+2.
  - A word occupies DATA_WIDTH*CLK_DIV cycles of tx_valid.
- Registered outputs: tx_bit, tx_valid and tx_sof are registered. tx_bit=0 whenever tx_valid=0.
- Empty rule: fifo_rd is never 1 in a cycle where fifo_empty=0 is not also sampled.
- No double pop: fifo_rd is never asserted in WAIT or in a non-final SHIFT cycle.
- enable deasserted mid-word: the current word completes fully; no further pops.
- Reset mid-word: the partial word is discarded. Outputs return to their reset values on the next edge, and the popped word is lost.
- After reset release: the first pop occurs no earlier than the first cycle with rst=1.

Test Plan:
1. Hold rst=0 for 20 cycles with enable=1, fifo_empty=0 -> fifo_rd, tx_valid, busy stay 0; word_count=0.
2. FIFO holds a single word 0xA5C3; CLK_DIV=1, MSB_FIRST=1; pop at cycle T -> tx_valid=1 over T+2..T+17; bits 1010010111000011; tx_sof=1 only at T+2; word_count=1; then IDLE, since fifo_empty=1.
3. Fill FIFO (depth 32) with 1..32, then enable -> exactly 32 fifo_rd pulses; words serialized in order 1..32 with one idle cycle between words; no fifo_rd while fifo_empty=1; word_count=32.
4. CLK_DIV=4, MSB_FIRST=0, word 0x0001 -> tx_bit=1 for the first 4 cycles, then 0 for 60 cycles; tx_sof=1 for the first 4 cycles only.
5. Drop enable during bit 5 of word 1 with words still queued -> word 1 completes; no further fifo_rd; word_count=1; FIFO contents remain.
6. Drive rst=0 during bit 8 of a word -> next edge: tx_valid=0, busy=0, word_count=0. After release, the next FIFO word is popped and transmitted from its first bit.
